vec_reduce: RTL and testbench



---
 rtl/vec_reduce_pkg.sv | 29 ++
 rtl/reduce_step.sv | 48 ++++
 rtl/vec_reduce.sv | 122 ++++++++++++
 tb/tb_vec_reduce.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vec_reduce_pkg.sv
// Shared types and default widths for the streaming vector reduction unit.
// Operation codes match the 3-bit command encoding seen on cmd_op.
package vec_reduce_pkg;

    localparam int F_DATA_DEF = 32;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [2:0] {
        RED_MAX    = 3'd0,
        RED_MIN    = 3'd1,
        RED_AND    = 3'd2,
        RED_OR     = 3'd3,
        RED_XOR    = 3'd4,
        RED_ARGMAX = 3'd5,
        RED_ARGMIN = 3'd6,
        RED_RSVD   = 3'd7
    } red_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_arg_op(input red_op_e op);
        return (op == RED_ARGMAX) || (op == RED_ARGMIN);
    endfunction

endpackage

// File: rtl/reduce_step.sv
// One fold step of the reduction: combines the running accumulator with a new element.
// Selection ops compare only the signed real half; the winner's whole word is kept.
module reduce_step
    import vec_reduce_pkg::*;
#(
    parameter int F_DATA = F_DATA_DEF,
    parameter int H_DATA = F_DATA / 2
) (
    input  logic [F_DATA-1:0] acc,
    input  logic [F_DATA-1:0] in_data,
    input  red_op_e           op,
    output logic [F_DATA-1:0] next_acc,
    output logic              take_new
);

    logic signed [H_DATA-1:0] acc_re;
    logic signed [H_DATA-1:0] in_re;
    logic                     in_gt;
    logic                     in_lt;

    assign acc_re = acc[F_DATA-1:H_DATA];
    assign in_re  = in_data[F_DATA-1:H_DATA];

    // Strict compares: on a tie the earlier element stays selected.
    assign in_gt = in_re > acc_re;
    assign in_lt = in_re < acc_re;

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        take_new = 1'b0;
        next_acc = acc;
        case (op)
            RED_MAX, RED_ARGMAX: begin
                take_new = in_gt;
                if (in_gt) next_acc = in_data;
            end
            RED_MIN, RED_ARGMIN: begin
                take_new = in_lt;
                if (in_lt) next_acc = in_data;
            end
            RED_AND: next_acc = acc & in_data;
            RED_OR:  next_acc = acc | in_data;
            RED_XOR: next_acc = acc ^ in_data;
            default: ;
        endcase
    end

endmodule

// File: rtl/vec_reduce.sv
// Streaming reduction unit: takes one command, folds cmd_len+1 packed complex elements,
// and returns a single registered result (with index for arg ops) over a valid/ready port.
module vec_reduce
    import vec_reduce_pkg::*;
#(
    parameter int F_DATA = F_DATA_DEF,
    parameter int H_DATA = F_DATA / 2,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [F_DATA-1:0] in_data,
    input  logic              in_last,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [F_DATA-1:0] res_data,
    output logic [LEN_W-1:0]  res_idx,
    output logic              res_err
);

    state_e            state_q;
    state_e            state_d;
    red_op_e           cmd_op_e;
    red_op_e           op_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  count_q;
    logic [F_DATA-1:0] acc_q;
    logic [LEN_W-1:0]  idx_q;
    logic              err_q;

    logic [F_DATA-1:0] next_acc;
    logic              take_new;
    logic              cmd_fire;
    logic              in_fire;
    logic              at_len;
    logic              vec_end;

    assign cmd_op_e = red_op_e'(cmd_op);
    assign cmd_fire = cmd_valid & cmd_ready;
    assign in_fire  = in_valid & in_ready;
    assign at_len   = (count_q == len_q);
    // Whichever end marker shows up first closes the vector.
    assign vec_end  = at_len | in_last;

    reduce_step #(
        .F_DATA (F_DATA),
        .H_DATA (H_DATA)
    ) u_step (
        .acc      (acc_q),
        .in_data  (in_data),
        .op       (op_q),
        .next_acc (next_acc),
        .take_new (take_new)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = (cmd_op_e == RED_RSVD) ? DONE : RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid && vec_end) state_d = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= RED_MAX;
            len_q   <= '0;
            count_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else if (cmd_fire) begin
            op_q    <= cmd_op_e;
            len_q   <= cmd_len;
            count_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            err_q   <= (cmd_op_e == RED_RSVD);
        end else if (in_fire) begin
            if (count_q == '0) begin
                acc_q <= in_data;
            end else begin
                acc_q <= next_acc;
                if (take_new && is_arg_op(op_q)) idx_q <= count_q;
            end
            // The count stops at the last element, so a full-length vector never wraps it.
            if (vec_end) err_q   <= (at_len != in_last);
            else         count_q <= count_q + LEN_W'(1);
        end
    end

    assign res_data = acc_q;
    assign res_idx  = idx_q;
    assign res_err  = err_q;

endmodule

// File: tb/tb_vec_reduce.sv
// Self-checking bench for vec_reduce: a table of directed vectors plus hand-written
// sequences for op 7, full-length count, result backpressure and mid-run reset.
module tb_vec_reduce;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [7:0]  res_idx;
    logic        res_err;

    int total = 0;
    int bad   = 0;

    vec_reduce #(.F_DATA(32), .LEN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_idx   (res_idx),
        .res_err   (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [7:0]  len;
        int          n;
        logic [31:0] data [4];
        int          last_at;
        int          exp_n;
        logic [31:0] exp_data;
        logic [7:0]  exp_idx;
        logic        exp_err;
        bit          gaps;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input int op, input int len, input int n,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input int last_at, input int exp_n, input logic [31:0] exp_data,
                                input int exp_idx, input bit exp_err, input bit gaps);
        vec_t v;
        v.name = name; v.op = 3'(op); v.len = 8'(len); v.n = n;
        v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
        v.last_at = last_at; v.exp_n = exp_n; v.exp_data = exp_data;
        v.exp_idx = 8'(exp_idx); v.exp_err = exp_err; v.gaps = gaps;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge after the command handshake.
    task automatic start_cmd(input string name, input int op, input int len);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_len   = 8'(len);
        check({name, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check({name, ".cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
        check({name, ".in_ready_start"}, 32'(in_ready), (op == 7) ? 32'd0 : 32'd1);
    endtask

    task automatic offer(input logic [31:0] d, input logic l, output bit took);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        took     = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [31:0] exp_data,
                                input logic [7:0] exp_idx, input logic exp_err);
        check({name, ".res_valid"}, 32'(res_valid), 32'd1);
        check({name, ".in_ready_done"}, 32'(in_ready), 32'd0);
        check({name, ".res_data"}, res_data, exp_data);
        check({name, ".res_idx"}, 32'(res_idx), 32'(exp_idx));
        check({name, ".res_err"}, 32'(res_err), 32'(exp_err));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({name, ".res_valid_after"}, 32'(res_valid), 32'd0);
        check({name, ".cmd_ready_after"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int consumed;
        bit took;
        consumed = 0;
        start_cmd(v.name, int'(v.op), int'(v.len));
        for (int i = 0; i < v.n; i++) begin
            if (v.gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            offer(v.data[i], (i == v.last_at), took);
            if (took) begin
                consumed++;
                if (consumed == v.exp_n)
                    check({v.name, ".res_valid_next"}, 32'(res_valid), 32'd1);
            end
        end
        check({v.name, ".consumed"}, 32'(consumed), 32'(v.exp_n));
        check_result(v.name, v.exp_data, v.exp_idx, v.exp_err);
    endtask

    initial begin
        bit took;
        int consumed;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; res_ready = 1'b0;

        vecs.push_back(mk("max_tie", 0, 3, 4, 32'h00050001, 32'hFFFE0002, 32'h00090003, 32'h00090004,
                          3, 4, 32'h00090003, 0, 1'b0, 1'b0));
        vecs.push_back(mk("argmax_tie", 5, 3, 4, 32'h00050001, 32'hFFFE0002, 32'h00090003, 32'h00090004,
                          3, 4, 32'h00090003, 2, 1'b0, 1'b0));
        vecs.push_back(mk("argmin", 6, 2, 3, 32'hFFFF0000, 32'h80000000, 32'h00070000, 32'h0,
                          2, 3, 32'h80000000, 1, 1'b0, 1'b0));
        vecs.push_back(mk("xor_gaps", 4, 1, 2, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0, 32'h0,
                          1, 2, 32'hF0F00F0F, 0, 1'b0, 1'b1));
        vecs.push_back(mk("and_early", 2, 5, 3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,
                          2, 3, 32'hFFFFFFFF, 0, 1'b1, 1'b0));
        vecs.push_back(mk("or_no_last", 3, 1, 3, 32'h000000F0, 32'h00000F00, 32'h0000F000, 32'h0,
                          -1, 2, 32'h00000FF0, 0, 1'b1, 1'b0));
        vecs.push_back(mk("min_imag", 1, 1, 2, 32'h00030009, 32'h00030001, 32'h0, 32'h0,
                          1, 2, 32'h00030009, 0, 1'b0, 1'b0));
        vecs.push_back(mk("max_signed", 0, 1, 2, 32'h80000001, 32'h7FFF0002, 32'h0, 32'h0,
                          1, 2, 32'h7FFF0002, 0, 1'b0, 1'b0));
        vecs.push_back(mk("argmax_one", 5, 0, 1, 32'hABCD1234, 32'h0, 32'h0, 32'h0,
                          0, 1, 32'hABCD1234, 0, 1'b0, 1'b0));
        vecs.push_back(mk("argmin_nolast", 6, 0, 2, 32'h00010000, 32'hFFFF0000, 32'h0, 32'h0,
                          -1, 1, 32'h00010000, 0, 1'b1, 1'b0));
        vecs.push_back(mk("argmin_late", 6, 3, 4, 32'h00030000, 32'h00010000, 32'hFFFB0001, 32'hFFFB0002,
                          3, 4, 32'hFFFB0001, 2, 1'b0, 1'b1));
        vecs.push_back(mk("xor_gaps2", 4, 1, 2, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0, 32'h0,
                          1, 2, 32'hF0F00F0F, 0, 1'b0, 1'b1));

        repeat (3) @(negedge clk);
        check("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.res_valid", 32'(res_valid), 32'd0);
        check("rst.res_data", res_data, 32'd0);
        check("rst.res_idx", 32'(res_idx), 32'd0);
        check("rst.res_err", 32'(res_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reserved op: result one cycle later, no elements consumed.
        start_cmd("rsvd", 7, 4);
        check_result("rsvd", 32'h0, 8'd0, 1'b1);

        // Full-length vector without in_last: stops at 256 elements, never wraps.
        consumed = 0;
        start_cmd("full_len", 5, 255);
        for (int i = 0; i < 257; i++) begin
            offer(32'(i) << 16, 1'b0, took);
            if (took) consumed++;
        end
        check("full_len.consumed", 32'(consumed), 32'd256);
        check_result("full_len", 32'h00FF0000, 8'd255, 1'b1);

        // Result backpressure: outputs frozen while res_ready stays low.
        start_cmd("bp", 3, 1);
        offer(32'h12340000, 1'b0, took);
        offer(32'h00005678, 1'b1, took);
        for (int i = 0; i < 10; i++) begin
            check("bp.hold_valid", 32'(res_valid), 32'd1);
            check("bp.hold_data", res_data, 32'h12345678);
            check("bp.hold_cmd_ready", 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        check_result("bp", 32'h12345678, 8'd0, 1'b0);

        // Reset in the middle of a run discards everything.
        start_cmd("mid_rst", 0, 5);
        offer(32'h00070000, 1'b0, took);
        offer(32'h00080000, 1'b0, took);
        rst_n = 1'b0;
        #1;
        check("mid_rst.cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst.in_ready", 32'(in_ready), 32'd0);
        check("mid_rst.res_valid", 32'(res_valid), 32'd0);
        check("mid_rst.res_data", res_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_vec(vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
